// File: rtl/flood_engine.sv
`timescale 1ns/1ps
// flood_engine: Flood-It board engine.
// Keeps a 32x32 flood-flag map beside an external synchronous board RAM.
// A game start absorbs the region around cell (0,0). A colour move repaints
// the flooded region and grows it with raster sweeps until one full sweep
// adds no new cell.
module flood_engine (
    input  logic       MASTER_CLOCK,
    input  logic       RESET_N,
    input  logic       BEGIN_GAME,
    output logic       STARTED_GAME,
    input  logic       COLOR_SEL_SIG,
    input  logic [2:0] COLOR_SELECTED,
    output logic       CURRENTLY_CHANGING_COLOR,
    input  logic [4:0] SIZE,
    input  logic [3:0] COLOR_NUM,
    output logic [9:0] MEM_ADDR,
    input  logic [2:0] MEM_RD_DATA,
    output logic       MEM_WE,
    output logic [2:0] MEM_WR_DATA,
    output logic [9:0] FLOOD_COUNT,
    output logic       GAME_WON
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_SWEEP_ADDR = 3'd2;
    localparam logic [2:0] ST_SWEEP_EVAL = 3'd3;
    localparam logic [2:0] ST_SWEEP_END  = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;
    localparam logic [2:0] ST_ACK_WAIT   = 3'd6;

    logic [2:0]  state;
    logic [4:0]  size_q;          // board edge latched at game start
    logic [3:0]  color_num_q;     // colour count latched at game start
    logic [2:0]  target_color;    // colour C being flooded
    logic [2:0]  flood_color;     // colour of the flooded region
    logic [4:0]  row;
    logic [4:0]  col;
    logic        sweep_changed;   // a cell was absorbed in this sweep
    logic        start_mode;      // current sweeps belong to a game start
    logic        start_phase;     // 0: (0,0) address out, 1: its data back
    logic [31:0] flags [32];      // flags[row][col]

    logic [4:0]  last_idx;
    logic [4:0]  row_up, row_dn, col_lf, col_rt;
    logic        flag_here;
    logic        any_nbr;
    logic        absorb;
    logic        null_move;
    logic [9:0]  size_sq;

    // Cell address, neighbour lookup and per-cell sweep decisions.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        last_idx  = size_q - 5'd1;
        row_up    = row - 5'd1;
        row_dn    = row + 5'd1;
        col_lf    = col - 5'd1;
        col_rt    = col + 5'd1;
        flag_here = flags[row][col];
        any_nbr   = 1'b0;
        if (row != 5'd0 && flags[row_up][col])   any_nbr = 1'b1;
        if (row != last_idx && flags[row_dn][col]) any_nbr = 1'b1;
        if (col != 5'd0 && flags[row][col_lf])   any_nbr = 1'b1;
        if (col != last_idx && flags[row][col_rt]) any_nbr = 1'b1;

        absorb = (state == ST_SWEEP_EVAL) && !flag_here &&
                 (MEM_RD_DATA == target_color) && any_nbr;

        MEM_ADDR    = {row, col};
        MEM_WE      = (state == ST_SWEEP_EVAL) && flag_here &&
                      (MEM_RD_DATA != target_color);
        MEM_WR_DATA = MEM_WE ? target_color : 3'd0;

        null_move = (COLOR_SELECTED == flood_color) ||
                    ({1'b0, COLOR_SELECTED} >= color_num_q) ||
                    GAME_WON;
        size_sq   = {5'd0, size_q} * {5'd0, size_q};
    end

    // Flood-flag map: cleared at game start, grown one cell at a time by sweeps.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        // NOTE: the flag array is reset because a reset must leave no cell flooded.
        if (!RESET_N) begin
            for (int r = 0; r < 32; r++) flags[r] <= '0;
        end else if (state == ST_IDLE && BEGIN_GAME) begin
            for (int r = 0; r < 32; r++) flags[r] <= '0;
            flags[0][0] <= 1'b1;
        end else if (absorb) begin
            flags[row][col] <= 1'b1;
        end
    end

    // Control FSM: start handshake, move handshake and the sweep loop.
    always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RESET_N) begin
            state                    <= ST_IDLE;
            STARTED_GAME             <= 1'b0;
            CURRENTLY_CHANGING_COLOR <= 1'b0;
            FLOOD_COUNT              <= 10'd0;
            GAME_WON                 <= 1'b0;
            size_q                   <= 5'd0;
            color_num_q              <= 4'd0;
            target_color             <= 3'd0;
            flood_color              <= 3'd0;
            row                      <= 5'd0;
            col                      <= 5'd0;
            sweep_changed            <= 1'b0;
            start_mode               <= 1'b0;
            start_phase              <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (BEGIN_GAME) begin
                        // Start has priority over a simultaneous move request.
                        size_q      <= SIZE;
                        color_num_q <= COLOR_NUM;
                        FLOOD_COUNT <= 10'd1;
                        GAME_WON    <= 1'b0;
                        row         <= 5'd0;
                        col         <= 5'd0;
                        start_mode  <= 1'b1;
                        start_phase <= 1'b0;
                        state       <= ST_START;
                    end else if (COLOR_SEL_SIG) begin
                        CURRENTLY_CHANGING_COLOR <= 1'b1;
                        target_color  <= COLOR_SELECTED;
                        start_mode    <= 1'b0;
                        row           <= 5'd0;
                        col           <= 5'd0;
                        sweep_changed <= 1'b0;
                        state         <= null_move ? ST_ACK_WAIT : ST_SWEEP_ADDR;
                    end
                end

                ST_START: begin
                    if (STARTED_GAME) begin
                        // Hold the acknowledge until the requester lets go.
                        if (!BEGIN_GAME) begin
                            STARTED_GAME <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end else if (!start_phase) begin
                        // (0,0) is on MEM_ADDR; its colour arrives next cycle.
                        start_phase <= 1'b1;
                    end else begin
                        target_color  <= MEM_RD_DATA;
                        sweep_changed <= 1'b0;
                        state         <= ST_SWEEP_ADDR;
                    end
                end

                ST_SWEEP_ADDR: begin
                    state <= ST_SWEEP_EVAL;
                end

                ST_SWEEP_EVAL: begin
                    if (absorb) begin
                        FLOOD_COUNT   <= FLOOD_COUNT + 10'd1;
                        sweep_changed <= 1'b1;
                    end
                    if (col == last_idx) begin
                        col <= 5'd0;
                        if (row == last_idx) begin
                            row   <= 5'd0;
                            state <= ST_SWEEP_END;
                        end else begin
                            row   <= row + 5'd1;
                            state <= ST_SWEEP_ADDR;
                        end
                    end else begin
                        col   <= col + 5'd1;
                        state <= ST_SWEEP_ADDR;
                    end
                end

                ST_SWEEP_END: begin
                    // Another pass is needed while cells keep being absorbed.
                    if (sweep_changed) begin
                        sweep_changed <= 1'b0;
                        state         <= ST_SWEEP_ADDR;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    flood_color <= target_color;
                    GAME_WON    <= (FLOOD_COUNT == size_sq);
                    if (start_mode) begin
                        STARTED_GAME <= 1'b1;
                        state        <= ST_START;
                    end else begin
                        state <= ST_ACK_WAIT;
                    end
                end

                ST_ACK_WAIT: begin
                    if (!COLOR_SEL_SIG) begin
                        CURRENTLY_CHANGING_COLOR <= 1'b0;
                        state                    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flood_engine.sv
`timescale 1ns/1ps
// tb_flood_engine: directed checks of start, moves, null moves, multi-sweep
// convergence, reset mid-sweep and start/move collision.
module tb_flood_engine;

    logic       MASTER_CLOCK;
    logic       RESET_N;
    logic       BEGIN_GAME;
    logic       STARTED_GAME;
    logic       COLOR_SEL_SIG;
    logic [2:0] COLOR_SELECTED;
    logic       CURRENTLY_CHANGING_COLOR;
    logic [4:0] SIZE;
    logic [3:0] COLOR_NUM;
    logic [9:0] MEM_ADDR;
    logic [2:0] MEM_RD_DATA;
    logic       MEM_WE;
    logic [2:0] MEM_WR_DATA;
    logic [9:0] FLOOD_COUNT;
    logic       GAME_WON;

    logic [2:0] ram [0:1023];
    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;

    flood_engine dut (
        .MASTER_CLOCK             (MASTER_CLOCK),
        .RESET_N                  (RESET_N),
        .BEGIN_GAME               (BEGIN_GAME),
        .STARTED_GAME             (STARTED_GAME),
        .COLOR_SEL_SIG            (COLOR_SEL_SIG),
        .COLOR_SELECTED           (COLOR_SELECTED),
        .CURRENTLY_CHANGING_COLOR (CURRENTLY_CHANGING_COLOR),
        .SIZE                     (SIZE),
        .COLOR_NUM                (COLOR_NUM),
        .MEM_ADDR                 (MEM_ADDR),
        .MEM_RD_DATA              (MEM_RD_DATA),
        .MEM_WE                   (MEM_WE),
        .MEM_WR_DATA              (MEM_WR_DATA),
        .FLOOD_COUNT              (FLOOD_COUNT),
        .GAME_WON                 (GAME_WON)
    );

    initial begin
        MASTER_CLOCK = 1'b0;
        forever #5 MASTER_CLOCK = ~MASTER_CLOCK;
    end

    // Synchronous board RAM: read data one cycle after the address.
    always @(posedge MASTER_CLOCK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WR_DATA;
        MEM_RD_DATA <= ram[MEM_ADDR];
    end

    // Count write strobes, sampled mid-cycle.
    always @(negedge MASTER_CLOCK) begin
        if (MEM_WE === 1'b1) we_count++;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic set_cell(input int r, input int c, input logic [2:0] v);
        ram[r * 32 + c] = v;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 1024; i++) ram[i] = 3'd0;
    endtask

    // Board {0,0;1,1} on a 2x2 grid.
    task automatic load_board2();
        clear_ram();
        set_cell(1, 0, 3'd1);
        set_cell(1, 1, 3'd1);
    endtask

    // 6x6 serpentine of colour 2: row 0 ->, down col 5, row 2 <-, down col 0, row 4 ->.
    task automatic load_serpentine();
        clear_ram();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) set_cell(r, c, 3'd1);
        for (int c = 0; c < 6; c++) begin
            set_cell(0, c, 3'd2);
            set_cell(2, c, 3'd2);
            set_cell(4, c, 3'd2);
            set_cell(5, c, 3'd0);
        end
        set_cell(1, 5, 3'd2);
        set_cell(3, 0, 3'd2);
    endtask

    // Raise BEGIN_GAME, count clock edges until STARTED_GAME, then release.
    task automatic start_game(output int lat, output int wn);
        int w0;
        int n;
        @(negedge MASTER_CLOCK);
        w0 = we_count;
        BEGIN_GAME = 1'b1;
        lat = 0;
        do begin
            @(posedge MASTER_CLOCK);
            lat++;
            @(negedge MASTER_CLOCK);
        end while (!STARTED_GAME && lat < 2000);
        wn = we_count - w0;
        BEGIN_GAME = 1'b0;
        n = 0;
        while (STARTED_GAME && n < 10) begin
            @(posedge MASTER_CLOCK);
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("start_ack_release", STARTED_GAME, 1'b0);
    endtask

    // Issue a move; report acknowledge latency, acknowledge width and writes.
    task automatic do_move(input logic [2:0] color, output int ccc_lat, output int ccc_hi, output int wn);
        int w0;
        @(negedge MASTER_CLOCK);
        w0 = we_count;
        COLOR_SELECTED = color;
        COLOR_SEL_SIG  = 1'b1;
        ccc_lat = 0;
        do begin
            @(posedge MASTER_CLOCK);
            ccc_lat++;
            @(negedge MASTER_CLOCK);
        end while (!CURRENTLY_CHANGING_COLOR && ccc_lat < 20);
        COLOR_SEL_SIG = 1'b0;
        ccc_hi = 0;
        while (CURRENTLY_CHANGING_COLOR && ccc_hi < 5000) begin
            ccc_hi++;
            @(posedge MASTER_CLOCK);
            @(negedge MASTER_CLOCK);
        end
        check("move_ack_release", CURRENTLY_CHANGING_COLOR, 1'b0);
        wn = we_count - w0;
    endtask

    initial begin
        int lat, wn, ccc_lat, ccc_hi, n, w0;

        RESET_N        = 1'b0;
        BEGIN_GAME     = 1'b0;
        COLOR_SEL_SIG  = 1'b0;
        COLOR_SELECTED = 3'd0;
        SIZE           = 5'd2;
        COLOR_NUM      = 4'd6;
        clear_ram();
        repeat (3) @(negedge MASTER_CLOCK);

        // Reset values.
        check("rst_started", STARTED_GAME, 0);
        check("rst_ccc", CURRENTLY_CHANGING_COLOR, 0);
        check("rst_we", MEM_WE, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_count", FLOOD_COUNT, 0);
        check("rst_won", GAME_WON, 0);
        RESET_N = 1'b1;

        // Start on 2x2 {0,0;1,1}: two sweeps of 9 cycles plus 4 overhead edges.
        load_board2();
        start_game(lat, wn);
        check("start2_latency", lat, 22);
        check("start2_we", wn, 0);
        check("start2_count", FLOOD_COUNT, 2);
        check("start2_won", GAME_WON, 0);

        // Null move: colour equals current colour 0.
        do_move(3'd0, ccc_lat, ccc_hi, wn);
        check("null_same_ccc_lat", ccc_lat, 1);
        check("null_same_ccc_hi", ccc_hi >= 1, 1);
        check("null_same_we", wn, 0);
        check("null_same_count", FLOOD_COUNT, 2);

        // Null move: colour 7 with 6 colours.
        do_move(3'd7, ccc_lat, ccc_hi, wn);
        check("null_range_ccc_hi", ccc_hi >= 1, 1);
        check("null_range_we", wn, 0);
        check("null_range_count", FLOOD_COUNT, 2);

        // Move to colour 1 floods the whole board.
        do_move(3'd1, ccc_lat, ccc_hi, wn);
        check("move_ccc_lat", ccc_lat, 1);
        check("move_we", wn, 2);
        check("move_ram00", ram[0], 1);
        check("move_ram01", ram[1], 1);
        check("move_count", FLOOD_COUNT, 4);
        check("move_won", GAME_WON, 1);

        // Any move after a win is null.
        do_move(3'd2, ccc_lat, ccc_hi, wn);
        check("null_won_we", wn, 0);
        check("null_won_count", FLOOD_COUNT, 4);

        // Serpentine 6x6 start: 7 sweeps of 73 cycles, 20 cells.
        SIZE = 5'd6;
        load_serpentine();
        start_game(lat, wn);
        check("serp_latency", lat, 4 + 7 * 73);
        check("serp_we", wn, 0);
        check("serp_count", FLOOD_COUNT, 20);
        check("serp_won", GAME_WON, 0);

        // Reset asserted while a write is in progress during SWEEP_EVAL.
        @(negedge MASTER_CLOCK);
        COLOR_SELECTED = 3'd1;
        COLOR_SEL_SIG  = 1'b1;
        n = 0;
        while (MEM_WE !== 1'b1 && n < 200) begin
            @(posedge MASTER_CLOCK);
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("rst_mid_we_seen", MEM_WE, 1);
        #1 RESET_N = 1'b0;
        #1;
        check("rst_mid_started", STARTED_GAME, 0);
        check("rst_mid_ccc", CURRENTLY_CHANGING_COLOR, 0);
        check("rst_mid_we", MEM_WE, 0);
        check("rst_mid_addr", MEM_ADDR, 0);
        check("rst_mid_wdata", MEM_WR_DATA, 0);
        check("rst_mid_count", FLOOD_COUNT, 0);
        check("rst_mid_won", GAME_WON, 0);
        COLOR_SEL_SIG = 1'b0;
        repeat (2) @(negedge MASTER_CLOCK);
        w0 = we_count;
        RESET_N = 1'b1;
        repeat (100) @(negedge MASTER_CLOCK);
        check("rst_mid_no_we_after", we_count - w0, 0);

        // Collision: start and move together; start is served first.
        SIZE      = 5'd2;
        COLOR_NUM = 4'd4;
        load_board2();
        @(negedge MASTER_CLOCK);
        COLOR_SELECTED = 3'd1;
        COLOR_SEL_SIG  = 1'b1;
        BEGIN_GAME     = 1'b1;
        n = 0;
        while (!STARTED_GAME && n < 200) begin
            @(posedge MASTER_CLOCK);
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("coll_started", STARTED_GAME, 1);
        check("coll_ccc_before", CURRENTLY_CHANGING_COLOR, 0);
        check("coll_start_count", FLOOD_COUNT, 2);
        BEGIN_GAME = 1'b0;
        n = 0;
        while (!CURRENTLY_CHANGING_COLOR && n < 20) begin
            @(posedge MASTER_CLOCK);
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("coll_ccc", CURRENTLY_CHANGING_COLOR, 1);
        COLOR_SEL_SIG = 1'b0;
        n = 0;
        while (CURRENTLY_CHANGING_COLOR && n < 500) begin
            @(posedge MASTER_CLOCK);
            @(negedge MASTER_CLOCK);
            n++;
        end
        check("coll_ccc_release", CURRENTLY_CHANGING_COLOR, 0);
        check("coll_count", FLOOD_COUNT, 4);
        check("coll_won", GAME_WON, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flood_engine.md
FLOOD_ENGINE -- requirements
Module: flood_engine

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL expose these ports:
- MASTER_CLOCK  in  1  100 MHz system clock
- RESET_N  in  1  async active-low reset
- BEGIN_GAME  in  1  start request; held high until STARTED_GAME is seen
- STARTED_GAME  out  1  start acknowledge
- COLOR_SEL_SIG  in  1  move request; held high until CURRENTLY_CHANGING_COLOR is seen
- COLOR_SELECTED  in  3  requested flood colour
- CURRENTLY_CHANGING_COLOR  out  1  move in progress / acknowledge
- SIZE  in  5  board edge, one of 2,6,10,14,18,22,26; sampled at game start
- COLOR_NUM  in  4  colour count, 3..8; sampled at game start
- MEM_ADDR  out  10  board RAM address = {row[4:0], col[4:0]}
- MEM_RD_DATA  in  3  board RAM read data; valid exactly 1 cycle after MEM_ADDR
- MEM_WE  out  1  board RAM write strobe
- MEM_WR_DATA  out  3  board RAM write data
- FLOOD_COUNT  out  10  number of cells in the flooded region
- GAME_WON  out  1  whole board flooded

Function
REQ-003 The block SHALL hold a 32x32 internal flood-flag array indexed like MEM_ADDR; only cells with row,col < latched SIZE participate.
REQ-004 The FSM SHALL have states IDLE, START, SWEEP_ADDR, SWEEP_EVAL, SWEEP_END, DONE, ACK_WAIT.
REQ-005 IDLE + BEGIN_GAME=1 -> START; on entry latch SIZE/COLOR_NUM, clear all flags, set flag(0,0), FLOOD_COUNT<=1, GAME_WON<=0, and read (0,0) to obtain target colour C.
REQ-006 START SHALL run sweeps with target C (absorbs the initial corner region) and, on convergence, assert STARTED_GAME and hold it until BEGIN_GAME is sampled low, then return to IDLE.
REQ-007 IDLE + COLOR_SEL_SIG=1 (BEGIN_GAME=0) -> assert CURRENTLY_CHANGING_COLOR on the next cycle; latch C<=COLOR_SELECTED.
REQ-008 Null move: if C equals current flood colour, C >= latched COLOR_NUM, or GAME_WON=1, skip sweeping, go to ACK_WAIT, and leave RAM, flags and counts unchanged.
REQ-009 Sweep, raster order row 0..SIZE-1, col 0..SIZE-1, 2 cycles per cell:
- SWEEP_ADDR drives MEM_ADDR.
- SWEEP_EVAL uses MEM_RD_DATA.
REQ-010 In SWEEP_EVAL, if flag=1 and data!=C: MEM_WE=1, MEM_WR_DATA=C for that cycle.
REQ-011 In SWEEP_EVAL, if flag=0, data==C, and any in-range 4-neighbour is flagged: set flag, FLOOD_COUNT+1, set sweep-changed bit.
REQ-012 Flags set earlier in the same sweep SHALL be visible to later cells.
REQ-013 SWEEP_END: if changed=1, clear it and start a new sweep; else go to DONE. Latency per sweep = 2*SIZE*SIZE+1 cycles.
REQ-014 DONE SHALL set the current flood colour to C and GAME_WON<=(FLOOD_COUNT==SIZE*SIZE), with the comparison at 10-bit width, then go to ACK_WAIT.
REQ-015 ACK_WAIT SHALL keep CURRENTLY_CHANGING_COLOR high until COLOR_SEL_SIG is sampled low, then drop it and return to IDLE; CURRENTLY_CHANGING_COLOR SHALL be high for at least 1 cycle.
REQ-016 MEM_WE SHALL be 0 in every state other than SWEEP_EVAL.
REQ-017 If BEGIN_GAME and COLOR_SEL_SIG are both high in IDLE, BEGIN_GAME SHALL win; COLOR_SEL_SIG is served afterwards.
REQ-018 Requests arriving outside IDLE SHALL be ignored until IDLE is re-entered.
REQ-019 BEGIN_GAME rising mid-sweep SHALL NOT abort the move.

Reset
REQ-020 On RESET_N=0, asynchronously: state=IDLE, STARTED_GAME=0, CURRENTLY_CHANGING_COLOR=0, MEM_WE=0, MEM_ADDR=0, MEM_WR_DATA=0, FLOOD_COUNT=0, GAME_WON=0, all flags=0, current colour=0.
REQ-021 Reset mid-sweep SHALL abandon the move with no further RAM writes; the next BEGIN_GAME fully reinitialises the block.

Verification
REQ-022 Start: SIZE=2, board {0,0;1,1}, BEGIN_GAME -> STARTED_GAME=1, FLOOD_COUNT=2, GAME_WON=0, no MEM_WE during START.
REQ-023 Move: same board, COLOR_SEL_SIG with colour 1 -> CURRENTLY_CHANGING_COLOR within 1 cycle; (0,0),(0,1) written 1; FLOOD_COUNT=4; GAME_WON=1.
REQ-024 Null move: colour equal to current colour, or 7 with COLOR_NUM=6 -> CURRENTLY_CHANGING_COLOR high >=1 cycle, zero MEM_WE, FLOOD_COUNT unchanged.
REQ-025 Multi-sweep: SIZE=6 serpentine region of colour 2 reachable only right-to-left -> converges after >1 sweep with correct FLOOD_COUNT; sweep count matches REQ-013 cycle budget.
REQ-026 Reset: RESET_N low during SWEEP_EVAL -> all outputs at reset values the same cycle; MEM_WE=0 thereafter.
REQ-027 Collision: BEGIN_GAME and COLOR_SEL_SIG high together -> STARTED_GAME first, then the move is processed.
